mem_bus_arbiter: RTL and testbench

Single-port arbiter and cycle sequencer directly upstream of the 64 KB linear memory. It accepts read/write requests from the 6502 core and read-only requests from the display DMA, grants one at a time with DMA priority, and drives the memory's enable/re_L/we_L/address/data pins. It returns read data with a one-cycle ack, and asserts cpu_halt while DMA owns the bus.

---
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-port memory arbiter and cycle sequencer (IDLE -> ACCESS -> ACK), DMA priority
// with a CPU anti-starvation counter. Define MEM_ROM_PROTECT_EN to block CPU writes at/above ROM_BASE.
module mem_bus_arbiter #(
    parameter int          CPU_STARVE_MAX = 4,
    parameter logic [15:0] ROM_BASE       = 16'h4000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_halt_o,
    input  logic        dma_req_i,
    input  logic [15:0] dma_addr_i,
    output logic [7:0]  dma_rdata_o,
    output logic        dma_ack_o,
    output logic        mem_enable_o,
    output logic        mem_re_l_o,
    output logic        mem_we_l_o,
    output logic [15:0] mem_address_o,
    inout  wire  [7:0]  mem_data_io,
    output logic        wr_fault_o,
    output logic [1:0]  state_o
);

`ifdef MEM_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    localparam logic [3:0] STARVE_MAX = 4'(CPU_STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_dma_q;
    logic        we_q;
    logic        blocked_q;
    logic        drive_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [3:0]  starve_q;
    logic        mem_enable_q, mem_re_l_q, mem_we_l_q;
    logic [7:0]  cpu_rdata_q, dma_rdata_q;
    logic        cpu_ack_q, dma_ack_q, halt_q, wr_fault_q;

    logic        grant_dma, grant_cpu, blocked_d;

    // Handshake: req is a level held with its operands until the one-cycle ack; requests are only
    // sampled in IDLE, so a req still high once IDLE is re-entered counts as a new request.
    always_comb begin
        grant_dma = dma_req_i && !((starve_q == STARVE_MAX) && cpu_req_i);
        grant_cpu = cpu_req_i && !grant_dma;
        blocked_d = ROM_PROTECT && cpu_we_i && (cpu_addr_i >= ROM_BASE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            owner_dma_q  <= 1'b0;
            we_q         <= 1'b0;
            blocked_q    <= 1'b0;
            drive_q      <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            starve_q     <= 4'd0;
            mem_enable_q <= 1'b0;
            mem_re_l_q   <= 1'b1;
            mem_we_l_q   <= 1'b1;
            cpu_rdata_q  <= 8'h00;
            dma_rdata_q  <= 8'h00;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            halt_q       <= 1'b0;
            wr_fault_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_dma) begin
                        state_q      <= ACCESS;
                        owner_dma_q  <= 1'b1;
                        we_q         <= 1'b0;
                        blocked_q    <= 1'b0;
                        addr_q       <= dma_addr_i;
                        mem_enable_q <= 1'b1;
                        mem_re_l_q   <= 1'b0;
                        mem_we_l_q   <= 1'b1;
                        drive_q      <= 1'b0;
                        halt_q       <= 1'b1;
                        if (!cpu_req_i)
                            starve_q <= 4'd0;
                        else if (starve_q < STARVE_MAX)
                            starve_q <= starve_q + 4'd1;
                    end else if (grant_cpu) begin
                        state_q      <= ACCESS;
                        owner_dma_q  <= 1'b0;
                        we_q         <= cpu_we_i;
                        blocked_q    <= blocked_d;
                        addr_q       <= cpu_addr_i;
                        wdata_q      <= cpu_wdata_i;
                        mem_enable_q <= !blocked_d;
                        mem_re_l_q   <= cpu_we_i;
                        mem_we_l_q   <= !(cpu_we_i && !blocked_d);
                        drive_q      <= cpu_we_i && !blocked_d;
                        halt_q       <= 1'b0;
                        starve_q     <= 4'd0;
                    end else begin
                        starve_q <= 4'd0;
                    end
                end
                ACCESS: begin
                    state_q      <= ACK;
                    mem_enable_q <= 1'b0;
                    mem_re_l_q   <= 1'b1;
                    mem_we_l_q   <= 1'b1;
                    drive_q      <= 1'b0;
                    if (!we_q) begin
                        if (owner_dma_q) dma_rdata_q <= mem_data_io;
                        else             cpu_rdata_q <= mem_data_io;
                    end
                    cpu_ack_q  <= !owner_dma_q;
                    dma_ack_q  <= owner_dma_q;
                    wr_fault_q <= blocked_q;
                end
                ACK: begin
                    state_q    <= IDLE;
                    cpu_ack_q  <= 1'b0;
                    dma_ack_q  <= 1'b0;
                    wr_fault_q <= 1'b0;
                    halt_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_data_io   = drive_q ? wdata_q : 8'hzz;
    assign mem_enable_o  = mem_enable_q;
    assign mem_re_l_o    = mem_re_l_q;
    assign mem_we_l_o    = mem_we_l_q;
    assign mem_address_o = addr_q;
    assign cpu_rdata_o   = cpu_rdata_q;
    assign dma_rdata_o   = dma_rdata_q;
    assign cpu_ack_o     = cpu_ack_q;
    assign dma_ack_o     = dma_ack_q;
    assign cpu_halt_o    = halt_q;
    assign wr_fault_o    = wr_fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model with a per-cycle compare,
// directed scenarios with literal expectations, then a randomized request stream.
module tb_mem_bus_arbiter;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_halt;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        dma_ack;
    logic        mem_enable, mem_re_l, mem_we_l;
    logic [15:0] mem_address;
    wire  [7:0]  mem_data;
    logic        wr_fault;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clock_i(clk), .reset_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_halt_o(cpu_halt),
        .dma_req_i(dma_req), .dma_addr_i(dma_addr), .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
        .mem_enable_o(mem_enable), .mem_re_l_o(mem_re_l), .mem_we_l_o(mem_we_l),
        .mem_address_o(mem_address), .mem_data_io(mem_data), .wr_fault_o(wr_fault),
        .state_o(state_dbg)
    );

    // ---------------- memory device (async read, posedge write) ----------------
    logic [7:0] dev_mem [65536];
    assign mem_data = (mem_enable && !mem_re_l) ? dev_mem[mem_address] : 8'hzz;
    always @(posedge clk) if (mem_enable && !mem_we_l) dev_mem[mem_address] <= mem_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [65536];
    int          cyc = 0, next_sample = 0, starve = 0, t_g = 0;
    bit          t_act = 0, t_dma, t_we, t_blk;
    logic [15:0] t_addr;
    logic [7:0]  t_wdata, t_rd;
    logic [7:0]  e_cpu_rd = 8'h00, e_dma_rd = 8'h00;
    logic [8:0]  exp_q [$];
    bit          chk_en = 0;

    task automatic start_txn(input bit dma, input bit we, input logic [15:0] a, input logic [7:0] d);
        t_act = 1; t_g = cyc; next_sample = cyc + 3;
        t_dma = dma; t_we = we; t_addr = a; t_wdata = d;
`ifdef MEM_ROM_PROTECT_EN
        t_blk = !dma && we && (a >= 16'h4000);
`else
        t_blk = 0;
`endif
        t_rd = ref_mem[a];
        if (we && !t_blk) ref_mem[a] = d;
    endtask

    // A grant at posedge g: ACCESS until g+1, ACK until g+2, next arbitration at g+3.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            t_act = 0; next_sample = cyc + 1; starve = 0;
            e_cpu_rd = 8'h00; e_dma_rd = 8'h00; exp_q.delete();
        end else begin
            if (t_act && cyc == t_g + 1 && !t_we) begin
                if (t_dma) e_dma_rd = t_rd; else e_cpu_rd = t_rd;
                exp_q.push_back({t_dma, t_rd});
            end
            if (cyc >= next_sample) begin
                if (dma_req && !(starve == STARVE_MAX && cpu_req)) begin
                    starve = cpu_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
                    start_txn(1, 0, dma_addr, 8'h00);
                end else if (cpu_req) begin
                    starve = 0;
                    start_txn(0, cpu_we, cpu_addr, cpu_wdata);
                end else begin
                    starve = 0;
                end
            end
        end
    end

    // ---------------- scoreboard / per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            bit acc, ack;
            logic [8:0] e;
            acc = t_act && (cyc == t_g);
            ack = t_act && (cyc == t_g + 1);
            check("ctrl", {mem_enable, mem_re_l, mem_we_l, cpu_ack, dma_ack, cpu_halt, wr_fault},
                  {acc && !t_blk, !(acc && !t_we), !(acc && t_we && !t_blk),
                   ack && !t_dma, ack && t_dma, (acc || ack) && t_dma, ack && t_blk});
            check("strobe_excl", {!mem_re_l && !mem_we_l}, 0);
            check("cpu_rdata", cpu_rdata, e_cpu_rd);
            check("dma_rdata", dma_rdata, e_dma_rd);
            if (acc) check("mem_address", mem_address, t_addr);
            if (acc && t_we && !t_blk) check("mem_data_wr", mem_data, t_wdata);
            if (acc && !t_we) check("mem_data_rd", mem_data, t_rd);
            if ((cpu_ack || dma_ack) && ack && !t_we) begin
                if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("ack_data", {dma_ack, dma_ack ? dma_rdata : cpu_rdata}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output bit flt, output bit saw_en);
        bit done = 0;
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0; flt = 0; saw_en = 0; rd = 8'h00;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (mem_enable) saw_en = 1;
            if (cpu_ack) begin rd = cpu_rdata; flt = wr_fault; done = 1; end
        end
        if (!done) check("cpu_op_timeout", 0, 1);
        cpu_req = 0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 16'h8000 + 16'($urandom_range(0, 15));
        return 16'h0100 + 16'($urandom_range(0, 15));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd, dval, cval, orig;
        logic [5:0] order;
        int lat, d_at, c_at, halt_n, n, cw, dw;
        bit flt, saw_en;

        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        dma_req = 0; dma_addr = 16'h0;
        @(negedge clk);
        chk_en = 1;
        check("rst_addr", mem_address, 16'h0000);
        check("rst_state", state_dbg, 2'd0);
        rst = 0;
        @(negedge clk);

        // CPU write then read back
        cpu_op(1, 16'h1234, 8'hA5, rd, lat, flt, saw_en);
        check("wr_latency", lat, 2);
        cpu_op(0, 16'h1234, 8'h00, rd, lat, flt, saw_en);
        check("rd_latency", lat, 2);
        check("rd_A5", rd, 8'hA5);

        // Simultaneous requests: DMA first, then CPU
        dev_mem[16'h2000] = 8'h3C; ref_mem[16'h2000] = 8'h3C;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; dma_req = 1; dma_addr = 16'h2000;
        d_at = -1; c_at = -1; halt_n = 0; dval = 0; cval = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cpu_halt) halt_n++;
            if (dma_ack) begin d_at = i; dval = dma_rdata; dma_req = 0; end
            if (cpu_ack) begin c_at = i; cval = cpu_rdata; cpu_req = 0; end
        end
        check("sim_dma_at", d_at, 2);
        check("sim_cpu_at", c_at, 5);
        check("sim_dma_data", dval, 8'h3C);
        check("sim_cpu_data", cval, 8'hA5);
        check("sim_halt_cycles", halt_n, 2);

        // Starvation: DMA held, CPU waiting
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; dma_req = 1; dma_addr = 16'h2000;
        order = 0; n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                order = {order[4:0], cpu_ack};
                n++;
                if (cpu_ack) cpu_req = 0;
                if (n == 6) dma_req = 0;
            end
        end
        dma_req = 0; cpu_req = 0;
        check("starve_count", n, 6);
        check("starve_order", order, 6'b000010);
        repeat (2) @(negedge clk);

        // Reset during a CPU write ACCESS
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'h77;
        @(negedge clk);
        rst = 1; cpu_req = 0;
        @(negedge clk);
        check("rst_wr_commit", dev_mem[16'h0040], 8'h77);
        check("rst_no_ack", cpu_ack, 0);
        check("rst_mid_addr", mem_address, 16'h0000);
        check("rst_mid_rdata", cpu_rdata, 8'h00);
        rst = 0;
        @(negedge clk);

        // Write above ROM_BASE
        orig = dev_mem[16'h8000];
        cpu_op(1, 16'h8000, 8'h11, rd, lat, flt, saw_en);
`ifdef MEM_ROM_PROTECT_EN
        check("rom_no_enable", saw_en, 0);
        check("rom_fault", flt, 1);
        cpu_op(0, 16'h8000, 8'h00, rd, lat, flt, saw_en);
        check("rom_readback", rd, orig);
`else
        check("ram_enable", saw_en, 1);
        check("ram_fault", flt, 0);
        cpu_op(0, 16'h8000, 8'h00, rd, lat, flt, saw_en);
        check("ram_readback", rd, 8'h11);
`endif

        // Random request stream with occasional reset
        cw = 0; dw = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (rst) rst = 0;
            else if ($urandom_range(0, 199) == 0) begin
                rst = 1; cpu_req = 0; dma_req = 0;
                continue;
            end
            if (cpu_req) begin
                cw++;
                if (cpu_ack) cpu_req = 0;
                else if (cw > 30) begin check("cpu_wait", cw, 30); cpu_req = 0; end
            end else if ($urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wdata = 8'($urandom); cw = 0;
            end
            if (dma_req) begin
                dw++;
                if (dma_ack) dma_req = 0;
                else if (dw > 30) begin check("dma_wait", dw, 30); dma_req = 0; end
            end else if ($urandom_range(0, 3) == 0) begin
                dma_req = 1; dma_addr = rand_addr(); dw = 0;
            end
        end
        rst = 0; cpu_req = 0; dma_req = 0;
        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
